// File: rtl/pred_rf_pkg.sv
// Shared types and helpers for the multi-ported predicate register file.
// Holds the clear-FSM state type, default sizes and write-port priority logic.
package pred_rf_pkg;

  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_NUM_WR   = 2;
  localparam int WR_MAX       = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } clr_st_e;

  // Later ports override earlier ones; returns {valid, data}.
  function automatic logic [1:0] wr_resolve(
    input logic [WR_MAX-1:0] hit,
    input logic [WR_MAX-1:0] dat,
    input int                n
  );
    logic [1:0] res;
    res = '0;
    for (int j = 0; j < WR_MAX; j++) begin
      if (j < n && hit[j]) res = {1'b1, dat[j]};
    end
    return res;
  endfunction

endpackage

// File: rtl/pred_regfile_mp_if.sv
// Issue-stage bundle between scheduler/compare units and the predicate file.
// master = scheduler side, slave = register file.
interface pred_regfile_mp_if
  import pred_rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD-1:0]    rd_data;
  logic [NUM_RD-1:0]    rd_pend;
  logic [NUM_WR-1:0]    wr_en;
  logic [NUM_WR*AW-1:0] wr_addr;
  logic [NUM_WR-1:0]    wr_data;
  logic                 pend_set_en;
  logic [AW-1:0]        pend_set_addr;
  logic                 clr_req;
  logic                 busy;
  logic                 clr_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output pend_set_en, pend_set_addr, clr_req,
    input  rd_data, rd_pend, busy, clr_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  pend_set_en, pend_set_addr, clr_req,
    output rd_data, rd_pend, busy, clr_done
  );

endinterface

// File: rtl/pred_rf_clear_fsm.sv
// Sequential bulk-clear engine: walks every register index once.
// Owns state, counter, busy and the clr_done pulse.
module pred_rf_clear_fsm
  import pred_rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_clr_req,
  output logic          o_busy,
  output logic          o_clr_done,
  output logic          o_clr_valid,
  output logic [AW-1:0] o_clr_idx
);

  clr_st_e       r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  // IDLE -> CLEAR (one index per cycle) -> DONE pulse -> IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_clr_req) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == AW'(NUM_REGS - 1)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_clr_done  = r_done;
  assign o_clr_valid = (r_state == ST_CLEAR);
  assign o_clr_idx   = r_cnt;

endmodule

// File: rtl/pred_regfile_mp.sv
// Multi-ported predicate register file with pending scoreboard and bulk clear.
// Optional macro PRED_RF_BYPASS_EN forwards same-cycle writes to reads.
module pred_regfile_mp
  import pred_rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int P0_TRUE  = 1
) (
  input logic              clk,
  input logic              reset_n,
  pred_regfile_mp_if.slave bus
);

  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] r_regs;
  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_reg_nxt;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic [NUM_REGS-1:0] w_src_reg;
  logic [NUM_REGS-1:0] w_src_pend;
  logic [NUM_RD-1:0]   r_rd_data;
  logic [NUM_RD-1:0]   r_rd_pend;
  logic [AW-1:0]       w_rd_addr [NUM_RD];
  logic [AW-1:0]       w_wr_addr [NUM_WR];
  logic                w_busy;
  logic                w_clr_valid;
  logic [AW-1:0]       w_clr_idx;

  pred_rf_clear_fsm #(
    .NUM_REGS (NUM_REGS)
  ) u_clr (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clr_req   (bus.clr_req),
    .o_busy      (w_busy),
    .o_clr_done  (bus.clr_done),
    .o_clr_valid (w_clr_valid),
    .o_clr_idx   (w_clr_idx)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign w_rd_addr[g] = bus.rd_addr[g*AW +: AW];
  end

  for (genvar g = 0; g < NUM_WR; g++) begin : g_wr
    assign w_wr_addr[g] = bus.wr_addr[g*AW +: AW];
  end

  // Next array state: clear step, else resolved writes then pend set
  always_comb begin : c_nxt
    logic [WR_MAX-1:0] v_hit;
    logic [WR_MAX-1:0] v_dat;
    logic [1:0]        v_res;
    w_reg_nxt  = r_regs;
    w_pend_nxt = r_pend;
    v_hit      = '0;
    v_dat      = '0;
    v_res      = '0;
    if (w_clr_valid) begin
      w_reg_nxt[w_clr_idx]  = 1'b0;
      w_pend_nxt[w_clr_idx] = 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        v_hit = '0;
        v_dat = '0;
        for (int j = 0; j < NUM_WR; j++) begin
          v_hit[j] = bus.wr_en[j] &&
                     (w_wr_addr[j] == AW'(r));
          v_dat[j] = bus.wr_data[j];
        end
        v_res = wr_resolve(v_hit, v_dat, NUM_WR);
        if (v_res[1] && !(P0_TRUE != 0 && r == 0)) begin
          w_reg_nxt[r]  = v_res[0];
          w_pend_nxt[r] = 1'b0;
        end
        if (bus.pend_set_en &&
            bus.pend_set_addr == AW'(r)) begin
          w_pend_nxt[r] = 1'b1;
        end
      end
    end
    if (P0_TRUE != 0) begin
      w_reg_nxt[0]  = 1'b0;
      w_pend_nxt[0] = 1'b0;
    end
  end

`ifdef PRED_RF_BYPASS_EN
  assign w_src_reg  = w_busy ? r_regs : w_reg_nxt;
  assign w_src_pend = w_busy ? r_pend : w_pend_nxt;
`else
  assign w_src_reg  = r_regs;
  assign w_src_pend = r_pend;
`endif

  // Commit the array and scoreboard
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_regs <= '0;
      r_pend <= '0;
    end else begin
      r_regs <= w_reg_nxt;
      r_pend <= w_pend_nxt;
    end
  end

  // Registered read ports; register 0 is hard-wired true when enabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
      r_rd_pend <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (P0_TRUE != 0 && w_rd_addr[i] == '0) begin
          r_rd_data[i] <= 1'b1;
          r_rd_pend[i] <= 1'b0;
        end else begin
          r_rd_data[i] <= w_src_reg[w_rd_addr[i]];
          r_rd_pend[i] <= w_src_pend[w_rd_addr[i]];
        end
      end
    end
  end

  assign bus.rd_data = r_rd_data;
  assign bus.rd_pend = r_rd_pend;
  assign bus.busy    = w_busy;

endmodule

// File: doc/pred_regfile_mp.md
Name: pred_regfile_mp

Overview:
- Parametrised, multi-ported predicate register file. Successor to the single-port 16x1 predicate file.
- Adds configurable depth, NUM_RD registered read ports and NUM_WR prioritised write ports.
- Adds a per-register pending scoreboard and a sequential bulk-clear engine.
- Sits in the issue stage: feeds predicate operands and hazard flags to the scheduler and takes predicate results back from the compare units.

Parameters:
- NUM_REGS, 16: number of 1-bit predicate registers; power of two, >=4.
- NUM_RD, 2: number of read ports.
- NUM_WR, 2: number of write ports.
- P0_TRUE, 1: when 1, register 0 always reads 1 and writes to it are dropped.
- AW, $clog2(NUM_REGS): address width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD  registered read data.
- rd_pend  out  NUM_RD  registered pending flag of each read address.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR  write data.
- pend_set_en  in  1  mark register pend_set_addr pending (producer issued).
- pend_set_addr  in  AW  register to mark pending.
- clr_req  in  1  start bulk clear.
- busy  out  1  bulk clear in progress.
- clr_done  out  1  single-cycle pulse when the clear completes.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all registers 0; all pending bits 0.
  - rd_data 0, rd_pend 0, busy 0, clr_done 0, FSM in IDLE, clear counter 0.
- Read latency is 1 cycle:
  - rd_data[i] and rd_pend[i] at edge t+1 reflect rd_addr[i] sampled at t and state before cycle-t updates. The optional feature changes this.
  - With P0_TRUE=1, address 0 returns rd_data=1 and rd_pend=0.
- Writes: committed at the rising edge when wr_en[j]=1.
  - Two ports writing the same address in one cycle: the highest-index port wins.
  - A write to register 0 with P0_TRUE=1 is dropped.
- Pending bits:
  - Any committed write to register r clears pend[r].
  - pend_set_en sets pend[pend_set_addr].
  - Set and write to the same register in one cycle: data is written and pend stays 1 (set wins; a newer producer is in flight).
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR with cnt=0.
  - CLEAR: busy=1. Each cycle reg[cnt]=0 and pend[cnt]=0, then cnt++. After clearing cnt=NUM_REGS-1 -> DONE.
  - DONE: clr_done=1, busy=0; next cycle -> IDLE.
  - Timing: clr_req at edge t gives busy high for cycles t+1..t+NUM_REGS and clr_done at t+NUM_REGS+1.
- While busy=1:
  - wr_en and pend_set_en are ignored (dropped; upstream stalls on busy).
  - clr_req is ignored.
  - Reads continue and return current, partially cleared contents.
- clr_req held high in DONE is not accepted that cycle; it is accepted in IDLE on the next cycle.
- Counter wraps naturally at NUM_REGS (AW bits).
- reset_n asserted mid-clear aborts to IDLE with all state reset.

Optional Feature:
- Macro: PRED_RF_BYPASS_EN.
- Defined: write-to-read forwarding.
  - rd_data at t+1 reflects the winning cycle-t write to the same address.
  - rd_pend at t+1 reflects cycle-t pend set/clear, with the same priority rules.
  - Forwarding is suppressed while busy.
  - Register 0 with P0_TRUE=1 is never forwarded.
- Undefined: reads see pre-update state only; the scheduler inserts one bubble on read-after-write.

Decomposition:
- Package pred_rf_pkg holds:
  - the FSM state typedef (IDLE/CLEAR/DONE);
  - localparam defaults for NUM_REGS/NUM_RD/NUM_WR;
  - a write-port priority resolve function returning winner-valid and data per address.
- One sub-module, pred_rf_clear_fsm, owns the state, the counter, busy and clr_done. It outputs clr_valid and clr_idx to the array.

Test Plan:
- Reset: hold reset_n=0 mid-activity -> all rd_data=0, rd_pend=0, busy=0; rd_addr=0 with P0_TRUE -> rd_data=1 after release.
- Write-port conflict: wr_en=2'b11, wr_addr both 5, wr_data={1,0} -> read addr 5 next cycle returns 1 (port 1 wins); port-0-only write of 0 then reads 0.
- Pending: pend_set addr 7 -> rd_pend=1. Write addr 7 -> rd_pend=0. Same-cycle set+write addr 7 with data 1 -> rd_data=1, rd_pend=1.
- Bulk clear: regs 1..15 set to 1 and all pending, pulse clr_req:
  - busy is high exactly 16 cycles;
  - a write to addr 3 mid-clear is dropped;
  - clr_done pulses once at t+17;
  - afterwards all reads are 0 and not pending, addr 0 reads 1.
- Reset mid-clear at cycle 8 of CLEAR -> busy=0, no clr_done; FSM accepts a new clr_req next cycle.
- Bypass: write addr 9 = 1 and read addr 9 in the same cycle:
  - with PRED_RF_BYPASS_EN -> rd_data=1 next cycle;
  - without -> rd_data=0, and 1 one cycle later.
